bf_stage_ctrl: RTL and testbench



---
 rtl/bf_stage_ctrl.sv | 139 +++++++++++++
 tb/tb_bf_stage_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bf_stage_ctrl.sv
// Sequencer for one radix-2 single-delay-feedback FFT butterfly stage:
// drives the block delay-buffer strobes, ALU enable, output path select and twiddle index.
module bf_stage_ctrl #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int TW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          buf_write,
    output logic          buf_read,
    output logic          alu_en,
    output logic          out_sel,
    output logic          out_valid,
    output logic [TW-1:0] tw_idx,
    output logic          frame_done,
    output logic          busy,
    output logic [CW-1:0] occ
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_BFLY_RD,
        S_BFLY_WR,
        S_DRAIN,
        S_FLUSH
    } state_e;

    localparam logic [TW-1:0] K_LAST   = TW'(DEPTH - 1);
    localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);

    state_e        state_q, state_d;
    logic [TW-1:0] k_q, k_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          drain_vld_q, drain_vld_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        in_ready    = 1'b0;
        buf_write   = 1'b0;
        buf_read    = 1'b0;
        alu_en      = 1'b0;
        out_sel     = 1'b0;
        out_valid   = 1'b0;
        tw_idx      = '0;
        frame_done  = 1'b0;
        state_d     = state_q;
        k_d         = k_q;
        drain_vld_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_FILL;
            end
            S_FILL: begin
                in_ready  = 1'b1;
                buf_write = in_valid;
                if (in_valid) begin
                    k_d = k_q + TW'(1);
                    if (k_q == K_LAST) state_d = S_BFLY_RD;
                end
            end
            S_BFLY_RD: begin
                if (in_valid) begin
                    buf_read = 1'b1;
                    state_d  = S_BFLY_WR;
                end
            end
            S_BFLY_WR: begin
                in_ready  = 1'b1;
                buf_write = 1'b1;
                alu_en    = 1'b1;
                out_valid = 1'b1;
                tw_idx    = k_q;
                k_d       = k_q + TW'(1);
                state_d   = (k_q == K_LAST) ? S_DRAIN : S_BFLY_RD;
            end
            S_DRAIN: begin
                buf_read    = 1'b1;
                drain_vld_d = 1'b1;
                k_d         = k_q + TW'(1);
                if (k_q == K_LAST) state_d = S_FILL;
            end
            S_FLUSH: begin
                k_d      = '0;
                buf_read = (occ_q != '0);
                if (occ_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // k has already advanced past the drained block, so the read index is k-1;
        // it wraps to DEPTH-1 on the last output, which is also the frame end.
        if (drain_vld_q) begin
            out_valid  = 1'b1;
            out_sel    = 1'b1;
            tw_idx     = k_q - TW'(1);
            frame_done = (k_q == '0);
        end

        if (clear && state_q != S_IDLE && state_q != S_FLUSH) begin
            state_d     = S_FLUSH;
            k_d         = '0;
            drain_vld_d = 1'b0;
        end

        occ_d = occ_q;
        if (buf_write)     occ_d = occ_q + CW'(1);
        else if (buf_read) occ_d = occ_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            occ_q       <= '0;
            drain_vld_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            state_q     <= state_d;
            k_q         <= k_d;
            occ_q       <= occ_d;
            drain_vld_q <= drain_vld_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign occ  = occ_q;

    a_no_wr_rd_overlap : assert property (@(posedge clk) disable iff (!rstn) !(buf_write && buf_read));
    a_no_overflow      : assert property (@(posedge clk) disable iff (!rstn) !(buf_write && occ_q == OCC_FULL));
    a_no_underflow     : assert property (@(posedge clk) disable iff (!rstn) !(buf_read && occ_q == '0));

endmodule

// File: tb/tb_bf_stage_ctrl.sv
// Self-checking bench for bf_stage_ctrl: directed scenarios plus random traffic,
// compared every cycle against a frame-position model of the stage.
module tb_bf_stage_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int TW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready, buf_write, buf_read, alu_en, out_sel, out_valid;
    logic [TW-1:0] tw_idx;
    logic          frame_done, busy;
    logic [CW-1:0] occ;

    bf_stage_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .buf_write(buf_write), .buf_read(buf_read), .alu_en(alu_en),
        .out_sel(out_sel), .out_valid(out_valid), .tw_idx(tw_idx), .frame_done(frame_done),
        .busy(busy), .occ(occ)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: position in the frame is the number of blocks accepted so far.
    bit m_run, m_flush, m_rd_pend;
    int m_acc, m_drain_rd, m_out_idx, m_occ;

    int cnt_acc, cnt_out, cnt_sum, cnt_fd, cnt_rd, cnt_wr;
    int acc_frame;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_flush = 0; m_rd_pend = 0;
        m_acc = 0; m_drain_rd = 0; m_out_idx = -1; m_occ = 0;
        acc_frame = 0;
    endtask

    task automatic clr_stats();
        cnt_acc = 0; cnt_out = 0; cnt_sum = 0; cnt_fd = 0; cnt_rd = 0; cnt_wr = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_buf_write"}, 32'(buf_write), 0);
        check({tag, "_buf_read"}, 32'(buf_read), 0);
        check({tag, "_alu_en"}, 32'(alu_en), 0);
        check({tag, "_out_sel"}, 32'(out_sel), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_tw_idx"}, 32'(tw_idx), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_occ"}, 32'(occ), 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic apply_reset(input string tag);
        #1 rstn = 1'b0;
        #1 check_all_zero(tag);
        enable = 1'b0; clear = 1'b0; in_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic step(input bit en, input bit clr, input bit iv);
        int  e_ready, e_wr, e_rd, e_alu, e_ov, e_sel, e_tw, e_fd, nxt_idx;
        bit  in_bfly_wr;
        @(negedge clk);
        in_bfly_wr = m_run && !m_flush && m_acc >= DEPTH && m_acc < 2 * DEPTH && m_rd_pend;
        enable   = en;
        clear    = clr;
        in_valid = in_bfly_wr ? 1'b1 : iv;
        #1;
        e_ready = 0; e_wr = 0; e_rd = 0; e_alu = 0; e_ov = 0; e_sel = 0; e_tw = 0; e_fd = 0;
        if (m_run && !m_flush) begin
            if (m_acc < DEPTH) begin
                e_ready = 1; e_wr = int'(in_valid);
            end else if (m_acc < 2 * DEPTH) begin
                if (!m_rd_pend) e_rd = int'(in_valid);
                else begin
                    e_ready = 1; e_wr = 1; e_alu = 1; e_ov = 1; e_tw = m_acc - DEPTH;
                end
            end else begin
                e_rd = 1;
            end
        end else if (m_flush) begin
            e_rd = (m_occ > 0) ? 1 : 0;
        end
        if (m_out_idx >= 0) begin
            e_ov = 1; e_sel = 1; e_tw = m_out_idx; e_fd = (m_out_idx == DEPTH - 1) ? 1 : 0;
        end

        check("in_ready", 32'(in_ready), e_ready);
        check("buf_write", 32'(buf_write), e_wr);
        check("buf_read", 32'(buf_read), e_rd);
        check("alu_en", 32'(alu_en), e_alu);
        check("out_valid", 32'(out_valid), e_ov);
        if (e_ov != 0) begin
            check("out_sel", 32'(out_sel), e_sel);
            check("tw_idx", 32'(tw_idx), e_tw);
        end
        check("frame_done", 32'(frame_done), e_fd);
        check("busy", 32'(busy), int'(m_run));
        check("occ", 32'(occ), m_occ);
        check("wr_rd_overlap", 32'(buf_write & buf_read), 0);

        if (frame_done) begin
            check("frame_accepts", acc_frame, 2 * DEPTH);
            acc_frame = 0;
        end
        if (in_ready && in_valid) acc_frame++;
        if (clr && busy) acc_frame = 0;

        cnt_acc += int'(in_ready && in_valid);
        cnt_out += int'(out_valid);
        cnt_sum += int'(out_valid && !out_sel);
        cnt_fd  += int'(frame_done);
        cnt_rd  += int'(buf_read);
        cnt_wr  += int'(buf_write);

        nxt_idx = -1;
        if (!m_run) begin
            if (en) m_run = 1;
        end else if (m_flush) begin
            if (m_occ == 0) begin m_run = 0; m_flush = 0; end
        end else begin
            if (m_acc < DEPTH) begin
                if (in_valid) m_acc++;
            end else if (m_acc < 2 * DEPTH) begin
                if (!m_rd_pend) begin
                    if (in_valid) m_rd_pend = 1;
                end else begin
                    m_rd_pend = 0; m_acc++;
                end
            end else begin
                nxt_idx = m_drain_rd;
                m_drain_rd++;
                if (m_drain_rd == DEPTH) begin m_drain_rd = 0; m_acc = 0; end
            end
            if (clr) begin
                m_flush = 1; m_acc = 0; m_rd_pend = 0; m_drain_rd = 0; nxt_idx = -1;
            end
        end
        m_occ     = m_occ + e_wr - e_rd;
        m_out_idx = nxt_idx;
    endtask

    task automatic scen1(input string tag);
        step(1, 0, 1);
        clr_stats();
        repeat (4 * DEPTH) step(0, 0, 1);
        step(0, 0, 0);
        check({tag, "_accepts"}, cnt_acc, 2 * DEPTH);
        check({tag, "_outputs"}, cnt_out, 2 * DEPTH);
        check({tag, "_sum_outputs"}, cnt_sum, DEPTH);
        check({tag, "_frame_done"}, cnt_fd, 1);
        check({tag, "_reads"}, cnt_rd, 2 * DEPTH);
        check({tag, "_writes"}, cnt_wr, 2 * DEPTH);
        @(negedge clk); #1;
        check({tag, "_occ_end"}, 32'(occ), 0);
    endtask

    bit pat3 [0:17] = '{1, 1, 0, 0, 0, 1, 1,  1, 1,  0, 0, 0,  1, 1, 1, 1, 1, 1};

    initial begin
        model_reset();
        clr_stats();
        apply_reset("reset");

        // Single frame.
        scen1("s1");

        // Back-to-back frames.
        apply_reset("s2_reset");
        step(1, 0, 1);
        clr_stats();
        repeat (8 * DEPTH) step(0, 0, 1);
        step(0, 0, 0);
        check("s2_accepts", cnt_acc, 4 * DEPTH);
        check("s2_outputs", cnt_out, 4 * DEPTH);
        check("s2_frame_done", cnt_fd, 2);

        // Gaps in FILL and BFLY_RD.
        apply_reset("s3_reset");
        step(1, 0, 0);
        clr_stats();
        for (int i = 0; i < 18; i++) step(0, 0, pat3[i]);
        repeat (DEPTH + 1) step(0, 0, 0);
        check("s3_accepts", cnt_acc, 2 * DEPTH);
        check("s3_outputs", cnt_out, 2 * DEPTH);
        check("s3_frame_done", cnt_fd, 1);

        // Clear in BFLY_WR with a full buffer.
        apply_reset("s4_reset");
        step(1, 0, 0);
        repeat (DEPTH) step(0, 0, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        clr_stats();
        repeat (DEPTH + 2) step(0, 0, 0);
        check("s4_flush_reads", cnt_rd, DEPTH);
        check("s4_flush_outputs", cnt_out, 0);
        @(negedge clk); #1;
        check("s4_busy_end", 32'(busy), 0);
        check("s4_occ_end", 32'(occ), 0);

        // Async reset in the middle of DRAIN, then a clean frame.
        apply_reset("s5_pre_reset");
        step(1, 0, 1);
        repeat (3 * DEPTH + 2) step(0, 0, 1);
        apply_reset("s5_mid_drain");
        scen1("s5");

        // Random traffic with occasional enable/clear.
        apply_reset("rand_reset");
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
